// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit:
// funct3 operation codes, FSM state encoding and counter sizing.
package muldiv_pkg;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    // Counter holds WIDTH-1 down to 0.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one iteration per cycle, sign fix applied on the final iteration.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Handshake: start is taken on a rising edge only in IDLE or DONE; busy is high
    // for every RUN cycle; done pulses one cycle with Result valid; start in RUN is dropped.
    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [2:0]       op;
    logic             neg;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] result_q;

    logic             signed_a;
    logic             signed_b;
    logic             sgn_a;
    logic             sgn_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             neg_in;
    logic             is_div;
    logic             div_zero;
    logic             div_ovf;
    logic             special;
    logic [WIDTH-1:0] special_res;

    always_comb begin
        signed_a = (funct3 == MULH) || (funct3 == MULHSU) || (funct3 == DIV) || (funct3 == REM);
        signed_b = (funct3 == MULH) || (funct3 == DIV) || (funct3 == REM);
        sgn_a    = signed_a & SrcA[WIDTH-1];
        sgn_b    = signed_b & SrcB[WIDTH-1];
        mag_a    = sgn_a ? (~SrcA + 1'b1) : SrcA;
        mag_b    = sgn_b ? (~SrcB + 1'b1) : SrcB;
        // Remainder takes the dividend's sign; products and quotients take the XOR.
        neg_in   = (funct3 == REM) ? sgn_a : (sgn_a ^ sgn_b);
        is_div   = funct3[2];
        div_zero = is_div && (SrcB == '0);
        div_ovf  = ((funct3 == DIV) || (funct3 == REM)) && (SrcA == MIN_NEG) && (SrcB == '1);
        special  = div_zero || div_ovf;
        special_res = '0;
        if (div_zero) begin
            special_res = funct3[1] ? SrcA : '1;
        end else if (div_ovf) begin
            special_res = funct3[1] ? '0 : MIN_NEG;
        end
    end

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] acc_n;
    logic [WIDTH-1:0] mq_n;

    // One iteration. Multiply: acc:mq shifts right with the partial sum entering acc.
    // Divide: acc:mq shifts left, quotient bit enters mq[0], acc keeps the remainder.
    always_comb begin
        mul_sum   = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
        div_shift = {acc, mq[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_ge    = div_shift >= {1'b0, opnd};
        if (op[2]) begin
            acc_n = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            mq_n  = {mq[WIDTH-2:0], div_ge};
        end else begin
            acc_n = mul_sum[WIDTH:1];
            mq_n  = {mul_sum[0], mq[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   final_res;

    always_comb begin
        prod   = {acc_n, mq_n};
        prod_s = neg ? (~prod + 1'b1) : prod;
        quo_s  = neg ? (~mq_n + 1'b1) : mq_n;
        rem_s  = neg ? (~acc_n + 1'b1) : acc_n;
        case (op)
            MUL:                final_res = prod_s[WIDTH-1:0];
            MULH, MULHSU, MULHU: final_res = prod_s[2*WIDTH-1:WIDTH];
            DIV, DIVU:          final_res = quo_s;
            default:            final_res = rem_s;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            op       <= MUL;
            neg      <= 1'b0;
            acc      <= '0;
            mq       <= '0;
            opnd     <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op  <= funct3;
                        neg <= neg_in;
                        acc <= '0;
                        if (special) begin
                            result_q <= special_res;
                            state    <= DONE;
                        end else begin
                            mq    <= is_div ? mag_a : mag_b;
                            opnd  <= is_div ? mag_b : mag_a;
                            count <= CW'(WIDTH - 1);
                            state <= RUN;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc   <= acc_n;
                    mq    <= mq_n;
                    count <= count - 1'b1;
                    if (count == '0) begin
                        result_q <= final_res;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign Result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized scoreboard bench for muldiv_unit against a plain-arithmetic RV32M model,
// with directed corner cases, start-during-RUN, back-to-back and mid-run reset scenarios.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;
    localparam logic [W-1:0] MINV = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   funct3;
    logic [W-1:0] SrcA;
    logic [W-1:0] SrcB;
    logic         busy;
    logic         done;
    logic [W-1:0] Result;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done), .Result(Result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_model(input logic [2:0] f3, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint sa, sb, ub, q;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        p  = '0;
        case (f3)
            MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            MULH:   begin p = sa * sb;                 return p[63:32]; end
            MULHSU: begin p = sa * ub;                 return p[63:32]; end
            MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            DIV: begin
                if (b == 0) return '1;
                if (a == MINV && b == '1) return MINV;
                q = sa / sb; p = q; return p[31:0];
            end
            REM: begin
                if (b == 0) return a;
                if (a == MINV && b == '1) return '0;
                q = sa % sb; p = q; return p[31:0];
            end
            DIVU: begin
                if (b == 0) return '1;
                return a / b;
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [W-1:0] a,
                                      input logic [W-1:0] b);
        if (!f3[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return ((f3 == DIV) || (f3 == REM)) && (a == MINV) && (b == '1);
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return MINV;
            3:       return W'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (busy && done) begin
                n_cmp++;
                n_err++;
                $display("FAIL busy_done_overlap: busy=%0b done=%0b expected not both", busy, done);
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: Result=0x%08h with no pending op", Result);
                end else begin
                    check("result", Result, exp_q.pop_front());
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge where done is seen so that a
    // following call asserts start in the done cycle (back-to-back).
    task automatic run_op(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inject_at);
        int lat, busy_cnt, exp_lat;
        exp_lat  = is_special(f3, a, b) ? 1 : W + 1;
        exp_q.push_back(ref_model(f3, a, b));
        funct3   = f3;
        SrcA     = a;
        SrcB     = b;
        start    = 1'b1;
        lat      = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (inject_at != 0 && k == inject_at) begin
                start  = 1'b1;
                funct3 = 3'($urandom);
                SrcA   = $urandom;
                SrcB   = $urandom;
            end
            if (inject_at != 0 && k == inject_at + 1) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
        check("latency", W'(lat), W'(exp_lat));
        check("busy_cycles", W'(busy_cnt), (exp_lat == 1) ? W'(0) : W'(W));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [2:0]   d_f3[13] = '{MUL, MULH, MULHU, MULHSU, DIV, REM, DIVU, REMU,
                               DIV, REMU, DIV, REM, MUL};
    logic [W-1:0] d_a[13]  = '{32'd7, MINV, '1, '1, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100,
                               32'd100, 32'd5, 32'd5, MINV, MINV, 32'd12345};
    logic [W-1:0] d_b[13]  = '{32'hFFFF_FFFD, MINV, '1, '1, 32'd2, 32'd2, 32'd7, 32'd7,
                               32'd0, 32'd0, '1, '1, 32'd3};

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        funct3 = MUL;
        SrcA   = '0;
        SrcB   = '0;
        idle(3);
        check("reset_busy", W'(busy), '0);
        check("reset_done", W'(done), '0);
        check("reset_result", Result, '0);
        reset = 1'b0;
        idle(2);

        for (int i = 0; i < 13; i++) begin
            run_op(d_f3[i], d_a[i], d_b[i], 0);
            idle(1);
        end

        // start during RUN cycle 5 must be ignored
        run_op(DIVU, 32'd1000, 32'd9, 5);
        // back-to-back: each op starts in the previous done cycle
        run_op(MULH, 32'h1234_5678, 32'hF000_0001, 0);
        run_op(REM, 32'hFFFF_FF00, 32'd7, 0);
        run_op(DIV, 32'd5, 32'd0, 0);
        run_op(MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0);
        idle(2);

        // reset at RUN cycle 10 aborts with no done pulse and clears Result
        funct3 = MUL;
        SrcA   = 32'd3;
        SrcB   = 32'd5;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idle(9);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", W'(busy), '0);
        check("abort_done", W'(done), '0);
        check("abort_result", Result, '0);
        reset = 1'b0;
        idle(40);
        run_op(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        idle(1);

        for (int i = 0; i < 200; i++) begin
            run_op(3'($urandom), pick(), pick(), ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 30)) : 0);
            idle($urandom_range(0, 2));
        end
        idle(3);

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL pending_ops: %0d left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
